// File: rtl/sfifo_wr_arb.sv
// ============================================================================
// sfifo_wr_arb
// ----------------------------------------------------------------------------
// Round-robin write arbiter that lets NUM_REQ requesters share the single
// write port of an sfifo. Each requester offers a valid/ready beat stream.
//
// The arbiter works in two states:
//   IDLE   : picks the next requester.
//   LOCKED : passes beats from the granted requester to the fifo.
//
// In IDLE it chooses the first valid requester at or after the round-robin
// pointer. It then moves to LOCKED on the next edge, so arbitration costs one
// cycle. In LOCKED it forwards beats until the grant is released. Every
// release is followed by one IDLE cycle.
//
// Optional feature (compile-time macro SFIFO_WR_ARB_BURST_LOCK_EN):
//   defined   : a grant lasts until a beat carrying req_last is written, or
//               until MAX_BURST beats have been written.
//   undefined : every written beat releases the grant (one beat per grant);
//               req_last and MAX_BURST have no effect.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  beat width, equal to the attached sfifo data width
//   MAX_BURST   beats per grant before a forced release (1..255)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   per-requester beat valid
//   req_data    per-requester beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    per-requester last-beat flag, qualified by req_valid
//   req_ready   per-requester beat accepted (valid & ready = transfer)
//   fifo_full   sfifo full flag
//   fifo_wr_cs  sfifo write chip select
//   fifo_wr_en  sfifo write enable
//   fifo_din    sfifo write data
//   grant       registered one-hot grant, zero while idle
//   busy        high while a grant is held (LOCKED)
// ============================================================================
module sfifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [7:0]         beat_cnt;

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;
    logic               locked;
    logic               xfer;
    logic [7:0]         beat_cnt_nxt;
    logic               burst_hit;
    logic               release_now;

    // Index arithmetic modulo NUM_REQ. NUM_REQ need not be a power of two,
    // so the wrap is explicit rather than relying on natural overflow.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: the first valid requester at or after rr_ptr,
    // scanning upward and wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && req_valid[wrap_add(rr_ptr, k)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign locked = (state == ST_LOCKED);

    // A beat moves only while locked, the granted requester is valid, and the
    // fifo has room. fifo_full stalls the burst without touching grant or count.
    assign xfer = locked && req_valid[gnt_idx] && !fifo_full;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign fifo_wr_cs = xfer;
    assign fifo_wr_en = xfer;
    assign fifo_din   = xfer ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy       = locked;

    // beat_cnt_nxt is the number of beats written, counting the current one.
    assign beat_cnt_nxt = beat_cnt + 8'd1;
    assign burst_hit    = (beat_cnt_nxt == 8'(MAX_BURST));

`ifdef SFIFO_WR_ARB_BURST_LOCK_EN
    assign release_now = xfer && (req_last[gnt_idx] || burst_hit);
`else
    // Single-beat grants: the burst flags have no effect in this build.
    logic unused_burst_cfg;
    assign unused_burst_cfg = ^{req_last, burst_hit};
    assign release_now      = xfer;
`endif

    // Arbitration FSM. The grant and pointer updates are registered here.
    // A release always lands in IDLE, so a new requester is never chosen in
    // the same cycle that the previous grant is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        state    <= ST_LOCKED;
                        gnt_idx  <= arb_idx;
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                        beat_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (release_now) begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        rr_ptr   <= wrap_add(gnt_idx, 1);
                        beat_cnt <= beat_cnt_nxt;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt_nxt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// ============================================================================
// tb_sfifo_wr_arb
// ----------------------------------------------------------------------------
// Drives sfifo_wr_arb with random stimulus over several traffic profiles.
// Every cycle, each output is compared against a behavioural model of the
// arbiter. The model keeps three things: the current owner (-1 when idle),
// the round-robin pointer, and the number of beats written in the current
// grant. It follows the macro SFIFO_WR_ARB_BURST_LOCK_EN the same way the
// design does.
// ============================================================================
module tb_sfifo_wr_arb;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 16;
    localparam int CYCLES     = 300;

`ifdef SFIFO_WR_ARB_BURST_LOCK_EN
    localparam bit BURST_LOCK = 1'b1;
`else
    localparam bit BURST_LOCK = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_cs;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state.
    int owner;
    int rrPtr;
    int beatsDone;

    // Traffic profile, given as percentages.
    int validPct;
    int lastPct;
    int fullPct;

    sfifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_cs (fifo_wr_cs),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = ($urandom_range(99) < validPct);
            req_last[i]  = ($urandom_range(99) < lastPct);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        end
        fifo_full = ($urandom_range(99) < fullPct);
    endtask

    // Checks the current outputs against the model, using the inputs that
    // are being driven now.
    task automatic checkCycle();
        logic [NUM_REQ-1:0]    expGrant;
        logic [NUM_REQ-1:0]    expReady;
        logic                  expWr;
        logic [DATA_WIDTH-1:0] expDin;
        expGrant = '0;
        expReady = '0;
        expWr    = 1'b0;
        expDin   = '0;
        if (owner >= 0) begin
            expGrant[owner] = 1'b1;
            if (req_valid[owner] && !fifo_full) begin
                expWr           = 1'b1;
                expReady[owner] = 1'b1;
                expDin          = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        checkOutput("grant",      32'(grant),      32'(expGrant));
        checkOutput("busy",       32'(busy),       32'(owner >= 0));
        checkOutput("req_ready",  32'(req_ready),  32'(expReady));
        checkOutput("fifo_wr_cs", 32'(fifo_wr_cs), 32'(expWr));
        checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(expWr));
        if (expWr) begin
            checkOutput("fifo_din", 32'(fifo_din), 32'(expDin));
        end
    endtask

    // Advances the model by one clock edge, using the inputs held across it.
    task automatic modelStep();
        int  idx;
        bit  rel;
        if (owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rrPtr + k) % NUM_REQ;
                if (req_valid[idx]) begin
                    owner     = idx;
                    beatsDone = 0;
                    break;
                end
            end
        end else if (req_valid[owner] && !fifo_full) begin
            beatsDone++;
            rel = BURST_LOCK ? (req_last[owner] || beatsDone == MAX_BURST) : 1'b1;
            if (rel) begin
                rrPtr = (owner + 1) % NUM_REQ;
                owner = -1;
            end
        end
    endtask

    task automatic checkResetOutputs(input string where);
        checkOutput({where, "_grant"},     32'(grant),      32'd0);
        checkOutput({where, "_busy"},      32'(busy),       32'd0);
        checkOutput({where, "_req_ready"}, 32'(req_ready),  32'd0);
        checkOutput({where, "_wr_cs"},     32'(fifo_wr_cs), 32'd0);
        checkOutput({where, "_wr_en"},     32'(fifo_wr_en), 32'd0);
    endtask

    // Asserts reset asynchronously partway through the cycle. The requesters
    // keep their current inputs, so the outputs must drop while traffic is
    // still offered. Returns with rst released at a falling edge.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        owner     = -1;
        rrPtr     = 0;
        beatsDone = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        owner     = -1;
        rrPtr     = 0;
        beatsDone = 0;
        validPct  = 0;
        lastPct   = 0;
        fullPct   = 0;

        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst");
        @(posedge clk);
        #1;
        checkResetOutputs("rst_edge");
        @(negedge clk);
        rst = 1'b0;

        // Profiles:
        //   0 mixed bursts
        //   1 all requesters always valid, single-beat bursts (rotation)
        //   2 long streams without last (forced release when locking)
        //   3 heavy back-pressure
        //   4 sparse traffic
        //   5 mixed traffic with asynchronous resets
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin validPct = 70;  lastPct = 30;  fullPct = 10; end
                1: begin validPct = 100; lastPct = 100; fullPct = 0;  end
                2: begin validPct = 95;  lastPct = 0;   fullPct = 0;  end
                3: begin validPct = 70;  lastPct = 25;  fullPct = 60; end
                4: begin validPct = 15;  lastPct = 50;  fullPct = 20; end
                default: begin validPct = 80; lastPct = 25; fullPct = 15; end
            endcase
            for (int c = 0; c < CYCLES; c++) begin
                applyStimulus();
                #1;
                checkCycle();
                @(posedge clk);
                modelStep();
                if (ph == 5 && (c % 37) == 20) begin
                    doReset();
                end else begin
                    @(negedge clk);
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
